// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    MISALIGNED_LOAD  = 2'd0,
    MISALIGNED_STORE = 2'd1,
    TIMEOUT          = 2'd2,
    ILLEGAL          = 2'd3
  } fault_cause_t;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  // funct3[1:0] is log2 of the access size, funct3[2] selects zero-extension
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  // Which funct3 values exist for a load or store; doubleword forms only on 64-bit.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3, input logic wide);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_D:             return wide;
      F3_BU, F3_HU:     return !is_store;
      F3_WU:            return wide && !is_store;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Main memory port between the load/store unit (master) and memory (slave).
// Latency: wires only.
// Backpressure: memory holds mem_busy high until it completes the request.
interface lsu_mem_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_strb;
  logic              mem_read;
  logic              mem_write;
  logic              mem_busy;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_addr, mem_wdata, mem_strb, mem_read, mem_write,
    input  mem_busy, mem_rdata
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_strb, mem_read, mem_write,
    output mem_busy, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes/data placement and load extraction/extension.
// Latency: purely combinational.
// Backpressure: none.
module lsu_align import lsu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] lane,
  input  logic [1:0]                size,
  input  logic                      zext,
  input  logic [XLEN-1:0]           st_data,
  input  logic [XLEN-1:0]           ld_raw,
  output logic [XLEN/8-1:0]         strb,
  output logic [XLEN-1:0]           st_lanes,
  output logic [XLEN-1:0]           ld_ext
);
  localparam int NB = XLEN / 8;

  logic [NB-1:0]   size_mask;
  logic [XLEN-1:0] ld_shift;
  logic            sign_bit;
  int              nbits;
  int              nbytes;

  // Shift lanes into place and extend the selected field from its top bit.
  always_comb begin
    nbytes = 1 << size;
    nbits  = 8 << size;
    if (nbits > XLEN) nbits = XLEN;
    for (int i = 0; i < NB; i++) size_mask[i] = (i < nbytes);
    strb     = size_mask << lane;
    st_lanes = st_data << {lane, 3'b000};
    ld_shift = ld_raw >> {lane, 3'b000};
    case (size)
      2'd0:    sign_bit = ld_shift[7];
      2'd1:    sign_bit = ld_shift[15];
      2'd2:    sign_bit = ld_shift[31];
      default: sign_bit = ld_shift[XLEN-1];
    endcase
    if (zext) sign_bit = 1'b0;
    for (int i = 0; i < XLEN; i++) ld_ext[i] = (i < nbits) ? ld_shift[i] : sign_bit;
  end

endmodule

// File: rtl/load_store_unit.sv
// Executes RV32I/RV64I loads and stores on the shared memory port with fault detection.
// Latency: 2 cycles start-to-done plus one per busy cycle; issue-time faults complete in 1.
// Backpressure: ready low while busy; waits on mem_busy, optional timeout after MAX_WAIT busy cycles.
module load_store_unit import lsu_pkg::*; #(
  parameter int XLEN           = 32,
  parameter int REG_SELECT_LEN = 5,
  parameter int MAX_WAIT       = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      ready,
  input  logic [31:0]               instruction,
  input  logic [XLEN-1:0]           rs1_data,
  input  logic [XLEN-1:0]           rs2_data,
  lsu_mem_if.master                 mem,
  output logic                      rd_we,
  output logic [REG_SELECT_LEN-1:0] rd_sel,
  output logic [XLEN-1:0]           rd_data,
  output logic                      done,
  output logic                      fault,
  output logic [1:0]                fault_cause,
  output logic [XLEN-1:0]           fault_addr
);
  localparam int          LANE_W     = $clog2(XLEN / 8);
  localparam int          CNT_W      = 16;
  localparam logic [31:0] MAX_WAIT_U = 32'(MAX_WAIT);

  state_t state_q, state_d;

  // Issue-time decode of the incoming instruction
  logic              dec_load, dec_store, dec_legal, dec_misaligned, issue_fault;
  logic [XLEN-1:0]   imm, ea_issue;
  logic [2:0]        dec_f3, amask;
  fault_cause_t      issue_cause;

  // Latched instruction context
  logic [REG_SELECT_LEN-1:0] rd_q;
  logic [2:0]                f3_q;
  logic                      store_q;
  logic [XLEN-1:0]           rs2_q, ea_q, rd_data_q, fault_addr_q;
  logic                      fault_q;
  fault_cause_t              cause_q;
  logic [CNT_W-1:0]          wait_cnt_q;
  logic [31:0]               wait_next;
  logic                      timeout_hit;

  logic [XLEN/8-1:0] lane_strb;
  logic [XLEN-1:0]   lane_wdata, ld_ext;

  // Decode, effective address and fault classification for the word on the issue bus
  always_comb begin
    dec_f3    = instruction[14:12];
    dec_load  = (instruction[6:0] == OPC_LOAD);
    dec_store = (instruction[6:0] == OPC_STORE);
    if (dec_store) imm = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
    else           imm = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
    ea_issue  = rs1_data + imm;
    dec_legal = (dec_load || dec_store) && f3_legal(dec_store, dec_f3, XLEN == 64);
    case (dec_f3[1:0])
      2'd0:    amask = 3'b000;
      2'd1:    amask = 3'b001;
      2'd2:    amask = 3'b011;
      default: amask = 3'b111;
    endcase
    dec_misaligned = |(ea_issue[2:0] & amask);
    issue_fault    = !dec_legal || dec_misaligned;
    issue_cause    = MISALIGNED_LOAD;
    if (!dec_legal)     issue_cause = ILLEGAL;
    else if (dec_store) issue_cause = MISALIGNED_STORE;
  end

  // Timeout fires on the busy cycle that brings the wait count up to MAX_WAIT
  always_comb begin
    wait_next   = 32'(wait_cnt_q) + 32'd1;
    timeout_hit = (MAX_WAIT != 0) && mem.mem_busy && (wait_next >= MAX_WAIT_U);
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .lane     (ea_q[LANE_W-1:0]),
    .size     (f3_q[1:0]),
    .zext     (f3_q[2]),
    .st_data  (rs2_q),
    .ld_raw   (mem.mem_rdata),
    .strb     (lane_strb),
    .st_lanes (lane_wdata),
    .ld_ext   (ld_ext)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and all state-decoded outputs
  always_comb begin
    state_d        = state_q;
    ready          = 1'b0;
    done           = 1'b0;
    fault          = 1'b0;
    rd_we          = 1'b0;
    mem.mem_read   = 1'b0;
    mem.mem_write  = 1'b0;
    mem.mem_strb   = '0;
    mem.mem_addr   = ea_q;
    mem.mem_wdata  = lane_wdata;
    rd_sel         = rd_q;
    rd_data        = rd_data_q;
    fault_cause    = cause_q;
    fault_addr     = fault_addr_q;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_d = issue_fault ? ST_DONE : ST_ACCESS;
      end
      ST_ACCESS: begin
        mem.mem_read  = !store_q;
        mem.mem_write = store_q;
        mem.mem_strb  = lane_strb;
        if (!mem.mem_busy || timeout_hit) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        fault   = fault_q;
        rd_we   = !fault_q && !store_q && (rd_q != '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture instruction context at issue, read data on completion, fault info on abort
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q         <= '0;
      f3_q         <= '0;
      store_q      <= 1'b0;
      rs2_q        <= '0;
      ea_q         <= '0;
      rd_data_q    <= '0;
      fault_q      <= 1'b0;
      cause_q      <= MISALIGNED_LOAD;
      fault_addr_q <= '0;
      wait_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          rd_q       <= REG_SELECT_LEN'(instruction[11:7]);
          f3_q       <= dec_f3;
          store_q    <= dec_store;
          rs2_q      <= rs2_data;
          ea_q       <= ea_issue;
          fault_q    <= issue_fault;
          cause_q    <= issue_cause;
          wait_cnt_q <= '0;
          if (issue_fault) fault_addr_q <= ea_issue;
        end
        ST_ACCESS: begin
          if (!mem.mem_busy) begin
            if (!store_q) rd_data_q <= ld_ext;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            if (timeout_hit) begin
              fault_q      <= 1'b1;
              cause_q      <= TIMEOUT;
              fault_addr_q <= ea_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit (XLEN=32, MAX_WAIT=4).
// Latency: checks start-to-done cycle counts and request duration per access.
// Backpressure: memory model holds mem_busy for a per-access number of request cycles.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, ready;
  logic [31:0] instruction, rs1_data, rs2_data;
  logic        rd_we, done, fault;
  logic [4:0]  rd_sel;
  logic [31:0] rd_data, fault_addr;
  logic [1:0]  fault_cause;

  always #5 clk = ~clk;

  lsu_mem_if #(.XLEN(32)) mem ();

  load_store_unit #(.XLEN(32), .REG_SELECT_LEN(5), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready),
    .instruction(instruction), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .mem(mem), .rd_we(rd_we), .rd_sel(rd_sel), .rd_data(rd_data),
    .done(done), .fault(fault), .fault_cause(fault_cause), .fault_addr(fault_addr)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          req_cycles;
    int          lat;
    bit          rd_we;
    logic [4:0]  rd_sel;
    logic [31:0] rd_data;
    bit          fault;
    logic [1:0]  cause;
    logic [31:0] faddr;
    bit          chk_faddr;
    int          issue_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   done_cnt = 0;
  int   req_cnt  = 0;
  int   busy_cfg = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] i_load(input logic [2:0] f3, input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd1, f3, rd, OPC_LOAD};
  endfunction

  function automatic logic [31:0] i_store(input logic [2:0] f3, input logic [11:0] imm);
    return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], OPC_STORE};
  endfunction

  function automatic exp_t e_load(input logic [31:0] addr, input logic [3:0] strb, input logic [4:0] rd,
                                  input logic [31:0] data, input int busy);
    exp_t e = '{default: 0};
    e.addr = addr; e.strb = strb; e.req_cycles = busy + 1; e.lat = busy + 2;
    e.rd_we = (rd != 5'd0); e.rd_sel = rd; e.rd_data = data;
    return e;
  endfunction

  function automatic exp_t e_store(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata,
                                   input int busy);
    exp_t e = '{default: 0};
    e.is_wr = 1'b1; e.addr = addr; e.strb = strb; e.wdata = wdata;
    e.req_cycles = busy + 1; e.lat = busy + 2;
    return e;
  endfunction

  function automatic exp_t e_fault(input fault_cause_t cause, input logic [31:0] faddr, input bit chk);
    exp_t e = '{default: 0};
    e.lat = 1; e.fault = 1'b1; e.cause = 2'(cause); e.faddr = faddr; e.chk_faddr = chk;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Memory model and output monitor: drive busy per request, pop scoreboard on done
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      req_cnt      = 0;
      mem.mem_busy = 1'b1;
    end else begin
      if (mem.mem_read || mem.mem_write) begin
        check("req_excl", 64'(mem.mem_read & mem.mem_write), 64'(0));
        if (sb.size() > 0) begin
          check("req_kind", 64'(mem.mem_write), 64'(sb[0].is_wr));
          check("req_addr", 64'(mem.mem_addr), 64'(sb[0].addr));
          check("req_strb", 64'(mem.mem_strb), 64'(sb[0].strb));
          if (sb[0].is_wr) check("req_wdata", 64'(mem.mem_wdata), 64'(sb[0].wdata));
        end
        mem.mem_busy = (req_cnt < busy_cfg);
        req_cnt++;
      end else begin
        mem.mem_busy = 1'b1;
      end
      if (rd_we && !done) check("rd_we_without_done", 64'(rd_we), 64'(0));
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check("spurious_done", 64'(done), 64'(0));
        end else begin
          e = sb.pop_front();
          check("done_latency", 64'(cyc - e.issue_cyc), 64'(e.lat));
          check("req_cycles", 64'(req_cnt), 64'(e.req_cycles));
          check("fault", 64'(fault), 64'(e.fault));
          if (e.fault) check("fault_cause", 64'(fault_cause), 64'(e.cause));
          if (e.fault && e.chk_faddr) check("fault_addr", 64'(fault_addr), 64'(e.faddr));
          check("rd_we", 64'(rd_we), 64'(e.rd_we));
          if (e.rd_we) begin
            check("rd_sel", 64'(rd_sel), 64'(e.rd_sel));
            check("rd_data", 64'(rd_data), 64'(e.rd_data));
          end
        end
        req_cnt = 0;
      end
    end
  end

  // Issue one instruction, optionally holding start into the busy period, and wait for done
  task automatic run_op(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] rdata, input int busy, input exp_t e, input bit hold);
    int base;
    @(negedge clk);
    check("ready_at_issue", 64'(ready), 64'(1));
    instruction   = instr;
    rs1_data      = rs1;
    rs2_data      = rs2;
    mem.mem_rdata = rdata;
    busy_cfg      = busy;
    e.issue_cyc   = cyc;
    sb.push_back(e);
    base  = done_cnt;
    start = 1'b1;
    @(negedge clk);
    if (hold) begin
      instruction = i_store(F3_W, 12'h040);
      @(negedge clk);
    end
    start = 1'b0;
    for (int k = 0; k < 40 && done_cnt == base; k++) @(negedge clk);
    if (done_cnt == base) check("done_wait_expired", 64'(done_cnt), 64'(base + 1));
  endtask

  exp_t te;
  int   rbase;

  initial begin
    reset = 1'b1; start = 1'b0; instruction = '0; rs1_data = '0; rs2_data = '0;
    mem.mem_rdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready",      64'(ready),          64'(1));
    check("rst_mem_read",   64'(mem.mem_read),   64'(0));
    check("rst_mem_write",  64'(mem.mem_write),  64'(0));
    check("rst_mem_strb",   64'(mem.mem_strb),   64'(0));
    check("rst_mem_addr",   64'(mem.mem_addr),   64'(0));
    check("rst_mem_wdata",  64'(mem.mem_wdata),  64'(0));
    check("rst_rd_we",      64'(rd_we),          64'(0));
    check("rst_done",       64'(done),           64'(0));
    check("rst_fault",      64'(fault),          64'(0));
    check("rst_rd_sel",     64'(rd_sel),         64'(0));
    check("rst_rd_data",    64'(rd_data),        64'(0));
    check("rst_fault_cause",64'(fault_cause),    64'(0));
    check("rst_fault_addr", 64'(fault_addr),     64'(0));

    run_op(i_load(F3_W, 5'd5, 12'd0),   32'h100, 0, 32'hDEADBEEF, 0, e_load(32'h100, 4'hF, 5'd5, 32'hDEADBEEF, 0), 0);
    run_op(i_load(F3_B, 5'd6, 12'd3),   32'h100, 0, 32'h80000000, 0, e_load(32'h103, 4'h8, 5'd6, 32'hFFFFFF80, 0), 0);
    run_op(i_load(F3_BU, 5'd7, 12'd3),  32'h100, 0, 32'h80000000, 0, e_load(32'h103, 4'h8, 5'd7, 32'h00000080, 0), 0);
    run_op(i_store(F3_H, 12'd2),        32'h100, 32'h1234, 0, 3, e_store(32'h102, 4'hC, 32'h12340000, 3), 0);
    run_op(i_load(F3_W, 5'd5, 12'd1),   32'h100, 0, 0, 0, e_fault(MISALIGNED_LOAD, 32'h101, 1), 1);
    run_op(i_load(F3_D, 5'd5, 12'd0),   32'h100, 0, 0, 0, e_fault(ILLEGAL, 32'h100, 1), 0);

    te = e_load(32'h100, 4'hF, 5'd8, 32'h0, 3);
    te.fault = 1'b1; te.cause = 2'(TIMEOUT); te.faddr = 32'h100; te.chk_faddr = 1'b1; te.rd_we = 1'b0;
    run_op(i_load(F3_W, 5'd8, 12'd0),   32'h100, 0, 32'h55555555, 100, te, 0);

    run_op(i_load(F3_W, 5'd0, 12'd0),   32'h100, 0, 32'h12345678, 0, e_load(32'h100, 4'hF, 5'd0, 32'h0, 0), 0);
    run_op(i_load(F3_W, 5'd9, 12'd8),   32'hFFFFFFFC, 0, 32'h11223344, 0, e_load(32'h4, 4'hF, 5'd9, 32'h11223344, 0), 0);
    run_op(i_store(F3_W, 12'd2),        32'h100, 32'hAAAA, 0, 0, e_fault(MISALIGNED_STORE, 32'h102, 1), 0);
    run_op(i_load(F3_H, 5'd10, 12'd2),  32'h100, 0, 32'hBEEF0000, 1, e_load(32'h102, 4'hC, 5'd10, 32'hFFFFBEEF, 1), 0);
    run_op(i_load(F3_HU, 5'd11, 12'd2), 32'h100, 0, 32'hBEEF0000, 0, e_load(32'h102, 4'hC, 5'd11, 32'h0000BEEF, 0), 0);
    run_op(i_store(F3_B, 12'd1),        32'h100, 32'h123456AB, 0, 0, e_store(32'h101, 4'h2, 32'h3456AB00, 0), 0);
    run_op(32'h00500293,                32'h100, 0, 0, 0, e_fault(ILLEGAL, 32'h0, 0), 0);
    run_op(i_load(3'b111, 5'd4, 12'd0), 32'h100, 0, 0, 0, e_fault(ILLEGAL, 32'h100, 1), 0);
    run_op(i_store(F3_D, 12'd0),        32'h100, 0, 0, 0, e_fault(ILLEGAL, 32'h100, 1), 0);
    run_op(i_load(F3_W, 5'd12, 12'hFFC), 32'h104, 0, 32'hCAFEF00D, 0, e_load(32'h100, 4'hF, 5'd12, 32'hCAFEF00D, 0), 1);

    // Reset in the second cycle of a stalled access: request drops, nothing completes
    @(negedge clk);
    instruction = i_load(F3_W, 5'd3, 12'd0); rs1_data = 32'h200; busy_cfg = 1000;
    rbase = done_cnt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_mid_req_active", 64'(mem.mem_read), 64'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_req_drop", 64'(mem.mem_read), 64'(0));
    check("rst_mid_ready", 64'(ready), 64'(1));
    reset = 1'b0; busy_cfg = 0;
    repeat (6) @(negedge clk);
    check("rst_mid_no_done", 64'(done_cnt), 64'(rbase));

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised successor to the separate load and store opcode units: one block executes all RV32I/RV64I load and store instructions against the shared main memory port. It computes the effective address, checks alignment, generates byte-lane strobes and shifted write data, waits on the memory busy handshake with an optional timeout, and sign/zero-extends read data for register writeback. It sits between the instruction decoder, the register array read buses and the memory main port, replacing the duplicated per-opcode drivers on that port.

## Interface
- XLEN, 32: data/address width; 32 or 64.
- REG_SELECT_LEN, 5: register index width.
- MAX_WAIT, 0: memory wait-cycle limit before timeout fault; 0 disables the timeout.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset; one clock, reset synchronous and active-high.
- start  in  1  issue strobe; sampled only while ready=1.
- ready  out  1  unit idle and able to accept start.
- instruction  in  32  instruction word, sampled with start.
- rs1_data, rs2_data  in  XLEN each  base register and store data, sampled with start.
- mem_addr  out  XLEN  byte address of the access.
- mem_wdata  out  XLEN  store data shifted into its byte lanes.
- mem_strb  out  XLEN/8  active byte lanes.
- mem_read, mem_write  out  1 each  request levels; mutually exclusive.
- mem_busy  in  1  memory not yet completing.
- mem_rdata  in  XLEN  read data; valid in the completing cycle.
- rd_we  out  1  register write enable, one-cycle pulse.
- rd_sel  out  REG_SELECT_LEN  destination register.
- rd_data  out  XLEN  extended load result.
- done  out  1  one-cycle completion pulse, with or without fault.
- fault  out  1  qualifies done; instruction aborted.
- fault_cause  out  2  0 misaligned load, 1 misaligned store, 2 timeout, 3 illegal encoding.
- fault_addr  out  XLEN  effective address of the faulting access.

## Operation
- States IDLE, ACCESS, DONE. ready = (state==IDLE).
- IDLE + start: latch rd, funct3, kind, rs2_data; EA = rs1_data + sext(imm). Load imm = instruction[31:20]; store imm = {instruction[31:25], instruction[11:7]}. Arithmetic is modulo 2^XLEN; wrap-around is not a fault.
- Opcode 0000011 = load, 0100011 = store; any other opcode is illegal.
- Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011 LD and 110 LWU are legal only when XLEN=64. Store funct3: 000 SB, 001 SH, 010 SW; 011 SD is legal only when XLEN=64. Every other encoding is illegal.
- Fault checks at issue: illegal encoding takes priority over misalignment. Misaligned means EA mod access size is non-zero. On a fault: go to DONE with no memory request; fault=1, cause set, fault_addr=EA.
- ACCESS: hold mem_read or mem_write, with mem_addr/mem_wdata/mem_strb stable, until the first cycle with mem_busy=0. That is the completion cycle: capture mem_rdata, drop the request next edge, go to DONE.
- Lanes: lane = EA mod (XLEN/8). mem_strb = size mask << lane. mem_wdata = rs2_data << (8*lane).
- Read path: take mem_rdata >> (8*lane), truncate to the access size, then sign-extend (B/H/W) or zero-extend (BU/HU/WU).
- Timeout: a counter clears on entry to ACCESS and increments on each busy cycle. If MAX_WAIT≠0 and the count reaches MAX_WAIT with mem_busy still 1: drop the request, go to DONE with cause 2.
- DONE: assert done for one cycle. For a non-faulting load with rd≠0, also pulse rd_we with rd_sel/rd_data. Next state is IDLE.
- start is ignored when ready=0.

## Timing
- Reset values: state IDLE, ready=1, mem_read=mem_write=0, mem_strb=0, mem_addr=mem_wdata=0, rd_we=done=fault=0, rd_sel=0, rd_data=0, fault_cause=0, fault_addr=0, counter=0.
- Reset mid-ACCESS: the request drops on the reset edge; no done and no rd_we follow.
- Zero-wait access: start at cycle 0, request in cycle 1, done/rd_we in cycle 2. Each busy cycle adds one cycle.
- Issue-time fault: done+fault in cycle 1, no request ever asserted.
- Back-to-back: a new start is accepted in the cycle after DONE (cycle 3 at the earliest).
- mem_busy is ignored outside ACCESS.

## Structure
- Package lsu_pkg holds: state_t enum; opcode constants; funct3 constants; fault_cause_t enum (MISALIGNED_LOAD, MISALIGNED_STORE, TIMEOUT, ILLEGAL).
- One combinational sub-module, lsu_align, parametrised on XLEN. It takes lane, size and signedness and produces mem_strb, the shifted write data and the extended read data.
- The FSM, address adder and timeout counter live in load_store_unit.

## Test plan
- Load, zero wait: LW x5 ← 0(x1), rs1=0x100, mem_rdata=0xDEADBEEF, busy=0 → request in cycle 1, mem_strb=4'b1111; done+rd_we in cycle 2, rd_sel=5, rd_data=0xDEADBEEF.
- Byte load extension: LB then LBU at EA=0x103, mem_rdata=0x80000000 → strb=4'b1000; rd_data=0xFFFFFF80 then 0x00000080.
- Store with wait: SH at EA=0x102, rs2=0x1234, busy high for 3 cycles → mem_wdata=0x12340000, strb=4'b1100 held 4 cycles; done in cycle 5, no rd_we.
- Issue-time faults: LW at EA=0x101 → done+fault in cycle 1, cause 0, fault_addr=0x101, no request. LD with XLEN=32 → cause 3.
- Timeout: MAX_WAIT=4, busy stuck high → request drops after 4 busy cycles, done+fault with cause 2. Reset asserted in cycle 2 of an access → request low next edge, no done.
- Edge cases: load to x0 → done with no rd_we. EA wrap: rs1=0xFFFFFFFC, imm=+8 → mem_addr=0x4, no fault.
